// File: rtl/riscv_instr_loader.sv
// Instruction-image loader: unpacks a framed 32-bit word stream into byte writes on the
// instr_config bus and holds the core in reset while an image is being written.
module riscv_instr_loader #(
   parameter int unsigned ADDR_W = 24,
   parameter logic [7:0]  MAGIC  = 8'hA5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       din,
   input  logic              val_in,
   output logic              ready_upward,
   output logic [ADDR_W-1:0] instr_config_addr,
   output logic [7:0]        instr_config_din,
   output logic              instr_config_wr_en,
   output logic              core_hold,
   output logic              load_done,
   output logic              hdr_err
);

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StData,
      StEmit,
      StDone
   } state_t;

   state_t              r_state;
   state_t              w_state_d;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_d;
   logic [ADDR_W-1:0]   r_rem;
   logic [ADDR_W-1:0]   w_rem_d;
   logic [31:0]         r_word;
   logic [31:0]         w_word_d;
   logic [2:0]          r_idx;
   logic [2:0]          w_idx_d;
   logic [ADDR_W-1:0]   r_cfg_addr;
   logic [ADDR_W-1:0]   w_cfg_addr_d;
   logic [7:0]          r_cfg_din;
   logic [7:0]          w_cfg_din_d;
   logic                r_wr_en;
   logic                w_wr_en_d;
   logic                r_hold;
   logic                w_hold_d;
   logic                r_done;
   logic                w_done_d;
   logic                r_err;
   logic                w_err_d;

   logic                w_ready_st;
   logic                w_accept;
   logic [7:0]          w_byte;

   // Gating with resetn keeps ready low throughout reset and high as soon as it releases.
   assign w_ready_st   = (r_state == StIdle) || (r_state == StLen) || (r_state == StData);
   assign ready_upward = w_ready_st & resetn;
   assign w_accept     = val_in & ready_upward;

   always_comb begin
      w_byte = r_word[7:0];
      case (r_idx[1:0])
         2'd0:    w_byte = r_word[7:0];
         2'd1:    w_byte = r_word[15:8];
         2'd2:    w_byte = r_word[23:16];
         default: w_byte = r_word[31:24];
      endcase
   end

   always_comb begin
      w_state_d    = r_state;
      w_addr_d     = r_addr;
      w_rem_d      = r_rem;
      w_word_d     = r_word;
      w_idx_d      = r_idx;
      w_cfg_addr_d = r_cfg_addr;
      w_cfg_din_d  = r_cfg_din;
      w_wr_en_d    = 1'b0;
      w_hold_d     = r_hold;
      w_done_d     = 1'b0;
      w_err_d      = 1'b0;

      case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (din[31:24] == MAGIC) begin
                  w_addr_d  = din[ADDR_W-1:0];
                  w_hold_d  = 1'b1;
                  w_state_d = StLen;
               end else begin
                  w_err_d = 1'b1;
               end
            end
         end
         StLen: begin
            if (w_accept) begin
               w_rem_d = din[ADDR_W-1:0];
               if (din[ADDR_W-1:0] == '0) begin
                  w_done_d  = 1'b1;
                  w_state_d = StDone;
               end else begin
                  w_state_d = StData;
               end
            end
         end
         StData: begin
            // Byte 0 goes out on the accept edge so the first write follows immediately.
            if (w_accept) begin
               w_word_d     = din;
               w_cfg_addr_d = r_addr;
               w_cfg_din_d  = din[7:0];
               w_wr_en_d    = 1'b1;
               w_addr_d     = r_addr + ADDR_W'(1);
               w_rem_d      = r_rem - ADDR_W'(1);
               w_idx_d      = 3'd1;
               w_state_d    = StEmit;
            end
         end
         StEmit: begin
            if ((r_idx == 3'd4) || (r_rem == '0)) begin
               if (r_rem == '0) begin
                  w_done_d  = 1'b1;
                  w_state_d = StDone;
               end else begin
                  w_state_d = StData;
               end
            end else begin
               w_cfg_addr_d = r_addr;
               w_cfg_din_d  = w_byte;
               w_wr_en_d    = 1'b1;
               w_addr_d     = r_addr + ADDR_W'(1);
               w_rem_d      = r_rem - ADDR_W'(1);
               w_idx_d      = r_idx + 3'd1;
            end
         end
         StDone: begin
            w_hold_d  = 1'b0;
            w_state_d = StIdle;
         end
         default: begin
            w_hold_d  = 1'b0;
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_rem      <= '0;
         r_word     <= '0;
         r_idx      <= '0;
         r_cfg_addr <= '0;
         r_cfg_din  <= '0;
         r_wr_en    <= 1'b0;
         r_hold     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_addr     <= w_addr_d;
         r_rem      <= w_rem_d;
         r_word     <= w_word_d;
         r_idx      <= w_idx_d;
         r_cfg_addr <= w_cfg_addr_d;
         r_cfg_din  <= w_cfg_din_d;
         r_wr_en    <= w_wr_en_d;
         r_hold     <= w_hold_d;
         r_done     <= w_done_d;
         r_err      <= w_err_d;
      end
   end

   assign instr_config_addr  = r_cfg_addr;
   assign instr_config_din   = r_cfg_din;
   assign instr_config_wr_en = r_wr_en;
   assign core_hold          = r_hold;
   assign load_done          = r_done;
   assign hdr_err            = r_err;

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Scoreboard bench for riscv_instr_loader: a byte-level image model queues expected writes and
// pulses; a negedge monitor pops and compares them as the loader produces them.
module tb_riscv_instr_loader;

   localparam int KW = 0;  // byte write
   localparam int KD = 1;  // load_done pulse
   localparam int KE = 2;  // hdr_err pulse

   typedef struct {
      int          kind;
      logic [23:0] addr;
      logic [7:0]  data;
      bit          after_wr;
   } ev_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] din;
   logic        val_in;
   logic        ready_upward;
   logic [23:0] instr_config_addr;
   logic [7:0]  instr_config_din;
   logic        instr_config_wr_en;
   logic        core_hold;
   logic        load_done;
   logic        hdr_err;

   int   checks = 0;
   int   errors = 0;
   ev_t  q[$];
   logic [7:0] img[$];
   int   hold_run = 0;
   int   last_hold = 0;
   bit   prev_wr = 1'b0;

   riscv_instr_loader #(.ADDR_W(24), .MAGIC(8'hA5)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .din                (din),
      .val_in             (val_in),
      .ready_upward       (ready_upward),
      .instr_config_addr  (instr_config_addr),
      .instr_config_din   (instr_config_din),
      .instr_config_wr_en (instr_config_wr_en),
      .core_hold          (core_hold),
      .load_done          (load_done),
      .hdr_err            (hdr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: every DUT output event must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t e;
      if (resetn) begin
         if (core_hold) hold_run++;
         else if (hold_run != 0) begin
            last_hold = hold_run;
            hold_run  = 0;
         end
         if (instr_config_wr_en) begin
            chk(!ready_upward && core_hold, "emit_ready_low_hold_high",
                {ready_upward, core_hold}, 2'b01);
            if (q.size() == 0) chk(1'b0, "unexpected_write", instr_config_addr, 0);
            else begin
               e = q.pop_front();
               chk(e.kind == KW && e.addr == instr_config_addr && e.data == instr_config_din,
                   "write", {e.kind[7:0], instr_config_addr, instr_config_din},
                   {e.kind[7:0], e.addr, e.data});
            end
         end
         if (load_done) begin
            if (q.size() == 0) chk(1'b0, "unexpected_load_done", 1, 0);
            else begin
               e = q.pop_front();
               chk(e.kind == KD, "load_done_order", KD, e.kind);
               if (e.after_wr) chk(prev_wr, "load_done_after_last_write", prev_wr, 1);
               chk(core_hold, "hold_during_done", core_hold, 1);
            end
         end
         if (hdr_err) begin
            if (q.size() == 0) chk(1'b0, "unexpected_hdr_err", 1, 0);
            else begin
               e = q.pop_front();
               chk(e.kind == KE, "hdr_err_order", KE, e.kind);
               chk(!core_hold, "hold_low_on_bad_magic", core_hold, 0);
            end
         end
         prev_wr = instr_config_wr_en;
      end else begin
         hold_run = 0;
         prev_wr  = 1'b0;
      end
   end

   // Called and returns at a negedge; the word transfers on the posedge just before return.
   task automatic send(input logic [31:0] w, input int gmax);
      int n = 0;
      int g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
         val_in = 1'b0;
         din    = $urandom;
         @(negedge clk);
      end
      din    = w;
      val_in = 1'b1;
      while (!ready_upward) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            chk(1'b0, "ready_timeout", n, 50);
            break;
         end
      end
      @(negedge clk);
      val_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(q.size() == 0, "scoreboard_drain", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Reference: byte i of the image lands at (start + i) mod 2^24, then one load_done.
   task automatic load_frame(input logic [23:0] start, input int gmax);
      int n = img.size();
      logic [31:0] w;
      for (int i = 0; i < n; i++) q.push_back('{KW, start + 24'(i), img[i], 1'b0});
      q.push_back('{KD, 24'h0, 8'h0, (n > 0)});
      send({8'hA5, start}, gmax);
      send({8'h00, 24'(n)}, gmax);
      for (int k = 0; k < (n + 3) / 4; k++) begin
         for (int b = 0; b < 4; b++)
            w[8*b +: 8] = (4 * k + b < n) ? img[4 * k + b] : 8'($urandom);
         send(w, gmax);
      end
      drain();
   endtask

   task automatic rand_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      val_in = 1'b0;
      din    = '0;
      #1;
      chk(!ready_upward && !instr_config_wr_en && !core_hold && !load_done && !hdr_err,
          "reset_ctrl_outputs",
          {ready_upward, instr_config_wr_en, core_hold, load_done, hdr_err}, 0);
      chk(instr_config_addr == 0 && instr_config_din == 0, "reset_addr_din",
          {instr_config_addr, instr_config_din}, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk(ready_upward, "ready_after_release", ready_upward, 1);
      @(negedge clk);

      // Basic load
      img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      load_frame(24'h000100, 0);

      // Zero length: load_done the cycle after len accept, hold for two cycles
      q.push_back('{KD, 24'h0, 8'h0, 1'b0});
      send(32'hA5000040, 0);
      send(32'h00000000, 0);
      chk(load_done, "zero_len_done_timing", load_done, 1);
      drain();
      chk(last_hold == 2, "zero_len_hold_cycles", last_hold, 2);

      // Bad magic, then a good frame
      q.push_back('{KE, 24'h0, 8'h0, 1'b0});
      send(32'h3C000010, 0);
      drain();
      rand_img(5);
      load_frame(24'h000200, 1);

      // Address wrap
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      load_frame(24'hFFFFFE, 0);

      // Backpressure and gaps on a 64-byte image, then assorted short frames
      rand_img(64);
      load_frame(24'($urandom), 3);
      for (int f = 0; f < 8; f++) begin
         rand_img(int'($urandom_range(13, 1)));
         load_frame(24'($urandom), 2);
         if (f % 3 == 0) begin
            q.push_back('{KE, 24'h0, 8'h0, 1'b0});
            send({8'h5A, 24'($urandom)}, 1);
            drain();
         end
      end

      // Reset during the second emitted byte of the first data word
      rand_img(8);
      q.push_back('{KW, 24'h000300, img[0], 1'b0});
      send(32'hA5000300, 0);
      send(32'h00000008, 0);
      send({img[3], img[2], img[1], img[0]}, 0);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk(!ready_upward && !instr_config_wr_en && !core_hold && !load_done && !hdr_err,
          "midload_reset_ctrl",
          {ready_upward, instr_config_wr_en, core_hold, load_done, hdr_err}, 0);
      chk(instr_config_addr == 0 && instr_config_din == 0, "midload_reset_addr_din",
          {instr_config_addr, instr_config_din}, 0);
      repeat (2) @(negedge clk);
      chk(q.size() == 0 && !load_done, "midload_no_done", {q.size(), load_done}, 0);
      resetn = 1'b1;
      #1;
      chk(ready_upward, "ready_after_midload_release", ready_upward, 1);
      @(negedge clk);
      rand_img(10);
      load_frame(24'h000400, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
